// File: rtl/fetch_pkg.sv
// Shared types and helpers for the frame fetch engine.
// Build option: FETCH_PERF_CNT_EN adds a back-pressure stall counter port.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_WAIT  = 3'd4
  } state_e;

  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

  // Bits needed to hold every value 0..v (at least 1).
  function automatic int cnt_bits(input int v);
    int r = 1;
    while ((1 << r) <= v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO absorbing BRAM read latency.
// Depth need not be a power of two; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 3,
  localparam int CW   = cnt_bits(DEPTH),
  localparam int PW   = cnt_bits(DEPTH - 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);

endmodule

// File: rtl/fetch_engine.sv
// Streams a MAX_ROW x MAX_COL frame from BRAM into the line buffer.
// Build option: FETCH_PERF_CNT_EN adds perf_stall_o.
module fetch_engine
  import fetch_pkg::*;
#(
  parameter int MAX_ROW   = 540,
  parameter int MAX_COL   = 540,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 19,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_run_i,
  output logic              fetch_done_o,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [DATA_W-1:0] bram_rdata_i,
  output logic              buf_valid_o,
  input  logic              buf_ready_i,
  output logic [DATA_W-1:0] buf_data_o,
  output logic              buf_eol_o,
  output logic              buf_last_o,
  output logic [2:0]        state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int TOTAL = MAX_ROW * MAX_COL;
  localparam int DEPTH = fifo_depth(RD_LAT);
  localparam int IW    = cnt_bits(TOTAL);
  localparam int CLW   = cnt_bits(MAX_COL - 1);
  localparam int FCW   = cnt_bits(DEPTH);

  state_e            state;
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     out_idx;
  logic [CLW-1:0]    out_col;
  logic [RD_LAT-1:0] sr;
  logic [FCW-1:0]    fifo_cnt;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              active;
  logic              clr;
  logic              pop;
  logic              last_hs;
  logic              credit;
  logic              issue;
  logic              col_end;
  int                pend;

  assign active  = (state == S_READ) || (state == S_DRAIN);
  assign clr     = (active || state == S_WAIT) && !fetch_run_i;
  assign pop     = !fifo_empty && buf_ready_i;
  assign col_end = (out_col == CLW'(MAX_COL - 1));
  assign last_hs = pop && (out_idx == IW'(TOTAL - 1));

  // Everything issued but not yet handed out, net of this cycle's pop,
  // must leave room for one more read.
  always_comb begin
    pend = int'(fifo_cnt) + int'(bram_en_o);
    for (int i = 0; i < RD_LAT; i++) pend += int'(sr[i]);
    credit = (pend - int'(pop)) < DEPTH;
  end

  assign issue = credit && fetch_run_i &&
                 (state == S_IDLE ||
                  (state == S_READ && rd_idx < IW'(TOTAL)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      fetch_done_o <= 1'b0;
      bram_en_o    <= 1'b0;
      bram_addr_o  <= '0;
      sr           <= '0;
      rd_idx       <= '0;
      out_idx      <= '0;
      out_col      <= '0;
    end else begin
      fetch_done_o <= 1'b0;
      bram_en_o    <= issue;
      sr           <= (sr << 1) | RD_LAT'(bram_en_o);
      if (issue) begin
        bram_addr_o <= ADDR_W'(BASE_ADDR) + ADDR_W'(rd_idx);
        rd_idx      <= rd_idx + IW'(1);
      end
      if (pop) begin
        out_idx <= out_idx + IW'(1);
        out_col <= col_end ? '0 : out_col + CLW'(1);
      end
      unique case (state)
        S_IDLE:  if (fetch_run_i) state <= S_READ;
        S_READ:  if (rd_idx == IW'(TOTAL)) state <= S_DRAIN;
        S_DRAIN: if (last_hs) begin
          state        <= S_DONE;
          fetch_done_o <= 1'b1;
        end
        S_DONE:  state <= S_WAIT;
        S_WAIT:  state <= S_WAIT;
        default: state <= S_IDLE;
      endcase
      if (clr) begin
        state        <= S_IDLE;
        fetch_done_o <= 1'b0;
        sr           <= '0;
        rd_idx       <= '0;
        out_idx      <= '0;
        out_col      <= '0;
      end
    end
  end

  fetch_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (sr[RD_LAT-1]),
    .pop   (pop),
    .din   (bram_rdata_i),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  assign buf_valid_o = !fifo_empty;
  assign buf_data_o  = fifo_empty ? '0 : fifo_dout;
  assign buf_eol_o   = !fifo_empty && col_end;
  assign buf_last_o  = !fifo_empty && (out_idx == IW'(TOTAL - 1));
  assign state_o     = state;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_o <= '0;
    end else if (state == S_IDLE && fetch_run_i) begin
      perf_stall_o <= '0;
    end else if (active && buf_valid_o && !buf_ready_i &&
                 perf_stall_o != '1) begin
      perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_engine.sv
// Bench for fetch_engine: 2x3 frame, RD_LAT=1, BRAM model and
// frame-order scoreboard checked every cycle on the falling edge.
module tb_fetch_engine;

  localparam int MR    = 2;
  localparam int MC    = 3;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int BASE  = 4;
  localparam int LAT   = 1;
  localparam int TOTAL = MR * MC;
  localparam int DEPTH = LAT + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          done;
  logic          en;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          eol;
  logic          last;
  logic [2:0]    state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf;
`endif

  always #5 clk = ~clk;

  fetch_engine #(
    .MAX_ROW   (MR),
    .MAX_COL   (MC),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .BASE_ADDR (BASE),
    .RD_LAT    (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_run_i  (run),
    .fetch_done_o (done),
    .bram_en_o    (en),
    .bram_addr_o  (addr),
    .bram_rdata_i (rdata),
    .buf_valid_o  (valid),
    .buf_ready_i  (ready),
    .buf_data_o   (data),
    .buf_eol_o    (eol),
    .buf_last_o   (last),
    .state_o      (state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_o (perf)
`endif
  );

  logic [DW-1:0] mem   [256];
  logic [DW-1:0] rpipe [LAT];

  always @(posedge clk) begin
    rpipe[0] <= mem[addr];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rdata = rpipe[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: phase 0 idle, 1 fetching, 2 done and waiting for run low.
  int            cyc = 0;
  int            phase = 0;
  int            n_iss = 0;
  int            n_beat = 0;
  int            perf_exp = 0;
  bit            last_hs_prev = 0;
  bit            stall_prev = 0;
  logic [DW-1:0] data_prev = '0;
  bit            rst_seen = 0;
  bit            rst_prev = 1;
  int            t_start, t_en_first, t_en_last, t_v_first, t_v_last, t_done;
  logic [TOTAL-1:0] eol_mask;

  always @(negedge clk) begin
    bit hs;
    cyc++;
    hs = valid && ready;
    if (rst_seen) begin
      if (!rst_prev)
        chk("reset_outputs",
            {en, valid, done, eol, last, state, data, addr}, 64'd0);
      if (en) begin
        chk("en_when_active", phase, 1);
        chk("bram_addr", addr, BASE + n_iss);
        n_iss++;
        chk("issue_bound", n_iss <= TOTAL, 1);
        chk("credit_bound", (n_iss - n_beat) <= DEPTH, 1);
        if (phase == 1) begin
          if (t_en_first < 0) t_en_first = cyc;
          t_en_last = cyc;
        end
      end
      if (stall_prev) begin
        chk("stall_valid_hold", valid, 1);
        chk("stall_data_hold", data, data_prev);
      end
      if (valid) begin
        chk("beat_in_frame", n_beat < TOTAL, 1);
        chk("beat_data", data, mem[BASE + n_beat]);
        chk("beat_eol", eol, (n_beat % MC) == MC - 1);
        chk("beat_last", last, n_beat == TOTAL - 1);
        if (phase == 1) begin
          if (t_v_first < 0) t_v_first = cyc;
          t_v_last = cyc;
          if (n_beat < TOTAL) eol_mask[n_beat] = eol;
        end
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_stall", perf, perf_exp);
`endif
      unique case (phase)
        0: begin
          chk("idle_state", state, 0);
          chk("idle_valid", valid, 0);
          chk("idle_done", done, 0);
        end
        1: begin
          chk("active_state", state inside {3'd1, 3'd2, 3'd3}, 1);
          chk("done_pulse", done, last_hs_prev);
        end
        default: begin
          chk("wait_state", state, 4);
          chk("wait_valid", valid, 0);
          chk("wait_done", done, 0);
        end
      endcase
      if (phase == 1 && valid && !ready) perf_exp++;
      last_hs_prev = (phase == 1) && hs && (n_beat == TOTAL - 1);
      stall_prev   = (phase == 1) && valid && !ready;
      data_prev    = data;
      if (hs) n_beat++;
    end
    if (!rst_n) begin
      phase = 0; n_iss = 0; n_beat = 0; perf_exp = 0;
      last_hs_prev = 0; stall_prev = 0;
    end else begin
      unique case (phase)
        0: if (run) begin
          phase = 1; n_iss = 0; n_beat = 0; perf_exp = 0;
          t_start = cyc; t_en_first = -1; t_v_first = -1;
          eol_mask = '0;
        end
        1: if (done) begin
          phase = 2; t_done = cyc;
        end else if (!run) begin
          phase = 0; n_iss = 0; n_beat = 0;
          last_hs_prev = 0; stall_prev = 0;
        end
        default: if (!run) begin
          phase = 0; n_iss = 0; n_beat = 0;
        end
      endcase
    end
    rst_prev = rst_n;
    if (!rst_n) rst_seen = 1;
  end

  int mode = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ready();
    unique case (mode)
      0: ready = 1'b1;
      1: ready = ((cyc - t_start) % 3) == 0;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_done();
    int k = 0;
    while (phase != 2 && k < 300) begin
      drive_ready();
      tick();
      k++;
    end
    chk("done_timeout", phase == 2, 1);
  endtask

  task automatic end_run();
    run = 1'b0;
    ready = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    rst_n = 1'b0; run = 1'b0; ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_state", state, 0);

    // Full-rate frame with literal timing.
    mode = 0; ready = 1'b1; run = 1'b1;
    wait_done();
    chk("first_en", t_en_first - t_start, 1);
    chk("last_en", t_en_last - t_start, 6);
    chk("first_valid", t_v_first - t_start, 3);
    chk("last_valid", t_v_last - t_start, 8);
    chk("done_cycle", t_done - t_start, 9);
    chk("eol_beats", eol_mask, 6'b100100);

    // Run held after done: no retrigger.
    repeat (5) tick();
    chk("hold_wait_state", state, 4);
    end_run();
    chk("back_to_idle", state, 0);

    // Ready pattern 1,0,0.
    mode = 1; run = 1'b1;
    wait_done();
    end_run();

    // Ready held low: issue stops at FIFO depth.
    mode = 0; ready = 1'b0; run = 1'b1;
    repeat (20) tick();
    chk("credit_fill", n_iss, DEPTH);
    chk("credit_no_beat", n_beat, 0);
    wait_done();
    end_run();

    // Abort after two beats, then restart from the base address.
    ready = 1'b1; run = 1'b1;
    tick();
    k = 0;
    while (n_beat < 2 && k < 50) begin tick(); k++; end
    chk("abort_beats", n_beat, 2);
    run = 1'b0; ready = 1'b0;
    tick();
    tick();
    chk("abort_state", state, 0);
    chk("abort_valid", valid, 0);
    ready = 1'b1; run = 1'b1;
    wait_done();
    end_run();

    // Four stall cycles before ready rises.
    run = 1'b1; ready = 1'b0;
    repeat (7) tick();
    mode = 0;
    wait_done();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_literal", perf, 4);
`endif
    end_run();

    // Reset while draining.
    ready = 1'b1; run = 1'b1;
    k = 0;
    while (n_iss < TOTAL && k < 50) begin tick(); k++; end
    ready = 1'b0;
    tick();
    chk("drain_state", state, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; run = 1'b0;
    tick();
    tick();

    // Random ready patterns with occasional aborts.
    mode = 2;
    for (int r = 0; r < 10; r++) begin
      run = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 8)) begin drive_ready(); tick(); end
      end else begin
        wait_done();
      end
      end_run();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
